// File: rtl/stopwatch_pkg.sv
// Shared encodings for the N-digit multiplexed stopwatch: mode codes,
// FSM states and active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package stopwatch_pkg;

  localparam logic [1:0] MODE_UP_ZERO   = 2'b00;
  localparam logic [1:0] MODE_UP_PRESET = 2'b01;
  localparam logic [1:0] MODE_DN_FULL   = 2'b10;
  localparam logic [1:0] MODE_DN_PRESET = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // All segments off (active low)
  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  localparam logic [6:0] SSEG_0 = 7'h40;
  localparam logic [6:0] SSEG_1 = 7'h79;
  localparam logic [6:0] SSEG_2 = 7'h24;
  localparam logic [6:0] SSEG_3 = 7'h30;
  localparam logic [6:0] SSEG_4 = 7'h19;
  localparam logic [6:0] SSEG_5 = 7'h12;
  localparam logic [6:0] SSEG_6 = 7'h02;
  localparam logic [6:0] SSEG_7 = 7'h78;
  localparam logic [6:0] SSEG_8 = 7'h00;
  localparam logic [6:0] SSEG_9 = 7'h10;

  // Switch nibbles above 9 are not BCD; pin them to 9
  function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

endpackage

// File: rtl/stopwatch_mux_n_bcd_to_sseg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Codes above 9 are not digits and show as blank.
module bcd_to_sseg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Straight lookup; anything non-BCD goes dark
  always_comb begin
    seg = SSEG_BLANK;
    case (bcd)
      4'd0: seg = SSEG_0;
      4'd1: seg = SSEG_1;
      4'd2: seg = SSEG_2;
      4'd3: seg = SSEG_3;
      4'd4: seg = SSEG_4;
      4'd5: seg = SSEG_5;
      4'd6: seg = SSEG_6;
      4'd7: seg = SSEG_7;
      4'd8: seg = SSEG_8;
      4'd9: seg = SSEG_9;
      default: seg = SSEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_mux_n.sv
// N-digit BCD stopwatch with up/down and preset modes, saturating at the
// count limits, driving a time-multiplexed seven-segment display. Single
// clock domain; count and scan rates come from enable strobes.
module stopwatch_mux_n
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESET_DIGITS = 2,
  parameter int COUNT_DIV     = 1_000_000,
  parameter int SCAN_DIV      = 100_000,
  parameter int BLANK_LZ      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startstop,
  input  logic [1:0]                 mode,
  input  logic [4*PRESET_DIGITS-1:0] sw,
  output logic [NUM_DIGITS-1:0]      an,
  output logic [6:0]                 sseg
);

  localparam int CW  = $clog2(COUNT_DIV);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int PB  = NUM_DIGITS - PRESET_DIGITS;  // lowest preset digit

  // ---------------------------------------------------------------------
  // startstop: two-flop synchroniser, edge-detect stage, registered pulse
  // ---------------------------------------------------------------------
  logic [2:0] ss_pipe;   // [0] meta, [1] synced, [2] previous synced
  logic       toggle;

  // Synchronise startstop and register a one-cycle pulse on its rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_pipe <= '0;
      toggle  <= 1'b0;
    end else begin
      ss_pipe <= {ss_pipe[1:0], startstop};
      toggle  <= ss_pipe[1] & ~ss_pipe[2];
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath declarations
  // ---------------------------------------------------------------------
  state_t                         state, state_nxt;
  logic [NUM_DIGITS-1:0][3:0]     digits, start_val, preset_val, step_val;
  logic [1:0]                     mode_q;     // mode the count was loaded with
  logic                           mode_chg;
  logic                           at_limit;
  logic                           tick;
  logic                           load_en, cnt_en, step_en;
  logic [CW-1:0]                  cnt;
  logic [SCW-1:0]                 scnt;
  logic                           scan_stb;
  logic [IW-1:0]                  scan_idx;
  logic [NUM_DIGITS-1:0][6:0]     dec_seg, seg_shown;

  assign mode_chg = (mode != mode_q);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register; reset parks in LOAD so release triggers a fresh load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  // Next state: toggle has priority over both mode changes and limit ticks
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (toggle)        state_nxt = ST_RUN;
        else if (mode_chg) state_nxt = ST_LOAD;
      end
      ST_RUN: begin
        if (toggle)                state_nxt = ST_IDLE;
        else if (tick && at_limit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (toggle || mode_chg) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // FSM outputs: load strobe, prescaler enable, digit-update strobe
  always_comb begin
    load_en = (state == ST_LOAD);
    cnt_en  = (state == ST_RUN);
    step_en = (state == ST_RUN) && tick && !toggle && !at_limit;
  end

  // ---------------------------------------------------------------------
  // Start value
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_preset
    if (i >= PB) begin : g_sw
      assign preset_val[i] = bcd_clamp(sw[4*(i-PB) +: 4]);
    end else begin : g_zero
      assign preset_val[i] = 4'd0;
    end
  end

  // Pick the load value for the current mode
  always_comb begin
    start_val = '0;
    case (mode)
      MODE_UP_ZERO:   start_val = '0;
      MODE_UP_PRESET: start_val = preset_val;
      MODE_DN_FULL:   for (int i = 0; i < NUM_DIGITS; i++) start_val[i] = 4'd9;
      MODE_DN_PRESET: start_val = preset_val;
      default:        start_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // BCD step and limit detection (direction from the loaded mode)
  // ---------------------------------------------------------------------
  // Ripple increment/decrement: 9->0 carries up, 0->9 borrows down
  always_comb begin : p_step
    logic c;
    c        = 1'b1;
    step_val = digits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (mode_q[1]) begin
          if (digits[i] == 4'd0) step_val[i] = 4'd9;
          else begin
            step_val[i] = digits[i] - 4'd1;
            c = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd9) step_val[i] = 4'd0;
          else begin
            step_val[i] = digits[i] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
  end

  // Limit is all-9s counting up and all-0s counting down
  always_comb begin : p_limit
    logic all9, all0;
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all9 = all9 && (digits[i] == 4'd9);
      all0 = all0 && (digits[i] == 4'd0);
    end
    at_limit = mode_q[1] ? all0 : all9;
  end

  // Digit register: load on LOAD, step on a non-limit tick, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= '0;
      mode_q <= MODE_UP_ZERO;
    end else if (load_en) begin
      digits <= start_val;
      mode_q <= mode;
    end else if (step_en) begin
      digits <= step_val;
    end
  end

  // ---------------------------------------------------------------------
  // Count prescaler: only runs in RUN so each RUN entry restarts the period
  // ---------------------------------------------------------------------
  assign tick = cnt_en && (cnt == CW'(COUNT_DIV - 1));

  // Count prescaler: cleared outside RUN and after each tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (!cnt_en || tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  // ---------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------
  assign scan_stb = (scnt == SCW'(SCAN_DIV - 1));

  // Free-running scan prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         scnt <= '0;
    else if (scan_stb) scnt <= '0;
    else               scnt <= scnt + SCW'(1);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    bcd_to_sseg u_dec (
      .bcd (digits[i]),
      .seg (dec_seg[i])
    );
  end

  // Leading-zero blanking: a digit is dark if it and every digit above it
  // are zero; digit 0 always shows so a zero count still reads "0"
  always_comb begin : p_blank
    logic lz;
    lz        = 1'b1;
    seg_shown = dec_seg;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz = lz && (digits[i] == 4'd0);
      if ((BLANK_LZ != 0) && (i != 0) && lz) seg_shown[i] = SSEG_BLANK;
    end
  end

  // Anode/segment registers update together, one digit per scan strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
      an       <= '1;
      sseg     <= SSEG_BLANK;
    end else if (scan_stb) begin
      an       <= ~(NUM_DIGITS'(1) << scan_idx);
      sseg     <= seg_shown[scan_idx];
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_mux_n.sv
// Directed bench for stopwatch_mux_n: 4 digits, 2 preset digits,
// COUNT_DIV=4, SCAN_DIV=3, leading-zero blanking on.
module tb_stopwatch_mux_n;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       startstop;
  logic [1:0] mode;
  logic [7:0] sw;
  logic [3:0] an;
  logic [6:0] sseg;

  int checks = 0;
  int errors = 0;
  int n;

  stopwatch_mux_n #(
    .NUM_DIGITS    (4),
    .PRESET_DIGITS (2),
    .COUNT_DIV     (4),
    .SCAN_DIV      (3),
    .BLANK_LZ      (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .startstop (startstop),
    .mode      (mode),
    .sw        (sw),
    .an        (an),
    .sseg      (sseg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n active edges, then sample 1 time unit later
  task automatic step(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  // Rising edge before edge k: state changes at edge k+3
  task automatic press();
    startstop = 1'b1;
    step(4);
    startstop = 1'b0;
  endtask

  function automatic logic [31:0] dig();
    return 32'(dut.digits);
  endfunction

  function automatic logic [31:0] st();
    return 32'(dut.state);
  endfunction

  initial begin
    reset = 1'b1; startstop = 1'b0; mode = 2'b00; sw = 8'h00;
    step(3);
    check("rst_an",     32'(an),   32'hF);
    check("rst_sseg",   32'(sseg), 32'h7F);
    check("rst_digits", dig(),     32'h0);
    check("rst_state",  st(),      32'(ST_LOAD));

    // Release: load 0000, first anode SCAN_DIV cycles later
    reset = 1'b0;
    step(1);
    check("load_state",  st(),  32'(ST_IDLE));
    check("load_digits", dig(), 32'h0);
    step(1);
    check("scan_pre_an", 32'(an), 32'hF);
    step(1);
    check("scan0_an",   32'(an),   32'hE);
    check("scan0_sseg", 32'(sseg), 32'h40);
    step(3);
    check("scan1_an",   32'(an),   32'hD);
    check("scan1_sseg", 32'(sseg), 32'h7F);

    // Mode 00: count up, first change exactly COUNT_DIV cycles after RUN
    press();
    check("run_state", st(), 32'(ST_RUN));
    step(3);
    check("up_hold", dig(), 32'h0);
    step(1);
    check("up_first", dig(), 32'h0001);
    step(3996);
    check("up_carry", dig(), 32'h1000);
    n = 0;
    while (dut.state != ST_DONE && n < 40000) begin step(1); n++; end
    check("up_done_cycles", 32'(n), 32'd36000);
    check("up_done_val",    dig(),  32'h9999);
    check("up_done_state",  st(),   32'(ST_DONE));
    step(8);
    check("up_sat", dig(), 32'h9999);

    // Mode 11, preset 12: 1200 down to 0000
    sw = 8'h12; mode = 2'b11;
    step(1);
    check("dn_load_state", st(), 32'(ST_LOAD));
    step(1);
    check("dn_preset",     dig(), 32'h1200);
    check("dn_idle_state", st(),  32'(ST_IDLE));
    press();
    step(4);
    check("dn_first", dig(), 32'h1199);
    step(800);
    check("dn_borrow", dig(), 32'h0999);
    n = 0;
    while (dut.state != ST_DONE && n < 10000) begin step(1); n++; end
    check("dn_done_cycles", 32'(n), 32'd4000);
    check("dn_done_val",    dig(),  32'h0);
    step(8);
    check("dn_sat",       dig(), 32'h0);
    check("dn_sat_state", st(),  32'(ST_DONE));

    // Mode 01 with an out-of-range nibble, then mode change in IDLE
    sw = 8'hF3; mode = 2'b01;
    step(2);
    check("clamp_val", dig(), 32'h9300);
    mode = 2'b00;
    step(1);
    check("reload_state", st(), 32'(ST_LOAD));
    step(1);
    check("reload_val", dig(), 32'h0);

    // Mode change during RUN is ignored
    press();
    mode = 2'b10;
    step(4);
    check("run_mode_val",   dig(), 32'h0001);
    check("run_mode_state", st(),  32'(ST_RUN));
    mode = 2'b00;

    // Toggle lands on the tick cycle: no update, go to IDLE
    press();
    check("coinc_val",   dig(), 32'h0001);
    check("coinc_state", st(),  32'(ST_IDLE));
    step(2);
    press();
    check("resume_state", st(), 32'(ST_RUN));
    step(3);
    check("resume_hold", dig(), 32'h0001);
    step(1);
    check("resume_first", dig(), 32'h0002);

    // Run to 0042 and stop (stop again coincides with a tick)
    step(160);
    check("lz_val", dig(), 32'h0042);
    press();
    check("lz_stop_val",   dig(), 32'h0042);
    check("lz_stop_state", st(),  32'(ST_IDLE));

    // Full scan with leading zeros blanked
    n = 0;
    while (an !== 4'hE && n < 20) begin step(1); n++; end
    check("lz_an0",   32'(an),   32'hE);
    check("lz_seg0",  32'(sseg), 32'h24);
    step(3);
    check("lz_an1",   32'(an),   32'hD);
    check("lz_seg1",  32'(sseg), 32'h19);
    step(3);
    check("lz_an2",   32'(an),   32'hB);
    check("lz_seg2",  32'(sseg), 32'h7F);
    step(3);
    check("lz_an3",   32'(an),   32'h7);
    check("lz_seg3",  32'(sseg), 32'h7F);

    // Preset 05 -> 0500, count to 0517, then async reset mid-count
    sw = 8'h05; mode = 2'b01;
    step(2);
    check("mid_preset", dig(), 32'h0500);
    press();
    step(68);
    check("mid_val", dig(), 32'h0517);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_an",     32'(an),   32'hF);
    check("mid_rst_sseg",   32'(sseg), 32'h7F);
    check("mid_rst_digits", dig(),     32'h0);
    check("mid_rst_state",  st(),      32'(ST_LOAD));
    step(1);
    reset = 1'b0;
    step(1);
    check("post_rst_state", st(),  32'(ST_IDLE));
    check("post_rst_val",   dig(), 32'h0500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
